// File: rtl/sample_seq_pkg.sv
// rtl/sample_seq_pkg.sv - shared constants and state encoding for the sample sequencer
package sample_seq_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_OVR_W   = 8;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_FETCH = 2'd1;
    localparam seq_state_t ST_PROC  = 2'd2;
    localparam seq_state_t ST_EMIT  = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear; increment beats clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            // a coincident clear restarts the count at the new event
            if (clr)
                cnt <= W'(1);
            else if (cnt != {W{1'b1}})
                cnt <= cnt + 1'b1;
        end else if (clr) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/sample_sequencer.sv
// rtl/sample_sequencer.sv - per-tick fetch/process/emit controller with overrun and timeout detection
module sample_sequencer
    import sample_seq_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int OVR_W   = DEF_OVR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              divide_now,
    output logic              src_req,
    input  logic              src_ack,
    input  logic [DATA_W-1:0] src_data,
    output logic              proc_start,
    output logic [DATA_W-1:0] proc_data,
    input  logic              proc_done,
    input  logic [DATA_W-1:0] proc_result,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err,
    output logic [OVR_W-1:0]  overrun_cnt,
    input  logic              err_clr
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    seq_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ovr_evt;
    logic              ack_ok;
    logic              to_evt;
    logic              done_ok;
    logic              emit_hs;

    always_comb begin
        ovr_evt = divide_now && (state != ST_IDLE);
        ack_ok  = (state == ST_FETCH) && src_ack;
        to_evt  = (state == ST_FETCH) && !src_ack && (wait_cnt == WAIT_LAST);
        // done is only trusted once the start pulse has been seen by the datapath
        done_ok = (state == ST_PROC) && proc_done && !proc_start;
        emit_hs = (state == ST_EMIT) && out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            src_req     <= 1'b0;
            proc_start  <= 1'b0;
            proc_data   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            proc_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en && divide_now) begin
                        state    <= ST_FETCH;
                        src_req  <= 1'b1;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (ack_ok) begin
                        src_req    <= 1'b0;
                        proc_data  <= src_data;
                        proc_start <= 1'b1;
                        state      <= ST_PROC;
                    end else if (to_evt) begin
                        src_req <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_PROC: begin
                    if (done_ok) begin
                        out_data  <= proc_result;
                        out_valid <= 1'b1;
                        state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (emit_hs) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (to_evt)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;

            if (ovr_evt)
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;
        end
    end

    sat_counter #(
        .W(OVR_W)
    ) u_ovr_cnt (
        .clk(clk),
        .rst(rst),
        .inc(ovr_evt),
        .clr(err_clr),
        .cnt(overrun_cnt)
    );

endmodule
